wta_disparity_select: RTL and testbench

WTA_DISPARITY_SELECT -- requirements
Module: wta_disparity_select

---
 rtl/wta_disparity_select.sv | 90 +++++++++
 tb/tb_wta_disparity_select.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/wta_disparity_select.sv
// Winner-take-all disparity selection: streams ND matching costs per pixel and
// reports the index of the minimum cost, the minimum itself and a uniqueness flag.
module wta_disparity_select #(
    parameter int ND      = 64,
    parameter int NBITC   = 12,
    parameter int UNIQ_TH = 8,
    localparam int NBITD  = $clog2(ND)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_dval,
    input  logic [NBITC-1:0] i_data,
    output logic             o_dval,
    output logic [NBITD-1:0] o_data,
    output logic [NBITC-1:0] o_cost,
    output logic             o_uniq
);

    // Handshake: valid-only streaming with no backpressure. A beat is accepted
    // on every rising edge where i_dval=1; o_dval is a one-cycle pulse and the
    // result fields stay stable until the next pulse.

    localparam logic [NBITD-1:0] LAST_D  = NBITD'(ND - 1);
    localparam logic [NBITC:0]   TH      = (NBITC+1)'(UNIQ_TH);
    localparam logic [NBITC-1:0] ALL_ONE = '1;

    logic [NBITD-1:0] d;
    logic [NBITC-1:0] best;
    logic [NBITC-1:0] second;
    logic [NBITD-1:0] idx;

    logic [NBITC-1:0] best_nxt;
    logic [NBITC-1:0] second_nxt;
    logic [NBITD-1:0] idx_nxt;
    logic [NBITC-1:0] margin;
    logic             last_beat;

    // Compare the incoming beat against the running best/second pair. The
    // last beat uses these next-state values directly so the decision
    // includes it without an extra cycle.
    always_comb begin
        best_nxt   = best;
        second_nxt = second;
        idx_nxt    = idx;
        if (d == '0) begin
            best_nxt   = i_data;
            second_nxt = ALL_ONE;
            idx_nxt    = '0;
        end else if (i_data < best) begin
            second_nxt = best;
            best_nxt   = i_data;
            idx_nxt    = d;
        end else if (i_data < second) begin
            second_nxt = i_data;
        end
    end

    assign last_beat = (d == LAST_D);
    assign margin    = second_nxt - best_nxt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            d      <= '0;
            best   <= '0;
            second <= ALL_ONE;
            idx    <= '0;
            o_dval <= 1'b0;
            o_data <= '0;
            o_cost <= '0;
            o_uniq <= 1'b0;
        end else begin
            o_dval <= 1'b0;
            if (i_dval) begin
                best   <= best_nxt;
                second <= second_nxt;
                idx    <= idx_nxt;
                if (last_beat) begin
                    d      <= '0;
                    o_dval <= 1'b1;
                    o_data <= idx_nxt;
                    o_cost <= best_nxt;
                    o_uniq <= ({1'b0, margin} >= TH);
                end else begin
                    d <= d + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wta_disparity_select.sv
// Directed bench for wta_disparity_select with ND=4, NBITC=12, UNIQ_TH=2.
module tb_wta_disparity_select;

    localparam int ND      = 4;
    localparam int NBITC   = 12;
    localparam int UNIQ_TH = 2;
    localparam int NBITD   = $clog2(ND);

    logic             i_clk;
    logic             i_rst;
    logic             i_dval;
    logic [NBITC-1:0] i_data;
    logic             o_dval;
    logic [NBITD-1:0] o_data;
    logic [NBITC-1:0] o_cost;
    logic             o_uniq;

    int tests_run;
    int tests_failed;
    int pulses;
    int base;

    wta_disparity_select #(
        .ND(ND),
        .NBITC(NBITC),
        .UNIQ_TH(UNIQ_TH)
    ) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_dval(i_dval),
        .i_data(i_data),
        .o_dval(o_dval),
        .o_data(o_data),
        .o_cost(o_cost),
        .o_uniq(o_uniq)
    );

    // Clock and reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial pulses = 0;
    always @(negedge i_clk) if (o_dval === 1'b1) pulses <= pulses + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic send(input logic [NBITC-1:0] c);
        i_dval = 1'b1;
        i_data = c;
        @(posedge i_clk);
        #1;
        i_dval = 1'b0;
    endtask

    task automatic chk_result(input string tag, input logic [31:0] d,
                              input logic [31:0] c, input logic [31:0] u);
        chk({tag, "_dval"}, 32'(o_dval), 32'd1);
        chk({tag, "_data"}, 32'(o_data), d);
        chk({tag, "_cost"}, 32'(o_cost), c);
        chk({tag, "_uniq"}, 32'(o_uniq), u);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        i_rst  = 1'b1;
        i_dval = 1'b0;
        i_data = '0;
        idle(2);
        chk("rst_dval", 32'(o_dval), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_cost", 32'(o_cost), 32'd0);
        chk("rst_uniq", 32'(o_uniq), 32'd0);
        i_rst = 1'b0;
        idle(1);

        // Basic pixel
        base = pulses;
        send(9); send(5); send(7);
        chk("basic_incomplete", 32'(o_dval), 32'd0);
        send(8);
        chk_result("basic", 1, 5, 1);
        idle(1);
        chk("basic_pulse_end", 32'(o_dval), 32'd0);
        chk("basic_hold_data", 32'(o_data), 32'd1);
        chk("basic_hold_cost", 32'(o_cost), 32'd5);
        chk("basic_pulses", 32'(pulses - base), 32'd1);

        // Tie keeps lowest index; equal cost becomes second
        send(4); send(4); send(6); send(6);
        chk_result("tie", 0, 4, 0);
        idle(1);

        // Gaps between beats
        base = pulses;
        send(9); idle(3);
        send(5); idle(3);
        send(7); idle(3);
        chk("gap_no_early", 32'(pulses - base), 32'd0);
        send(8);
        chk_result("gap", 1, 5, 1);
        idle(3);
        chk("gap_pulses", 32'(pulses - base), 32'd1);

        // Reset mid-pixel discards the partial pixel
        base = pulses;
        send(1); send(1);
        i_rst = 1'b1;
        idle(1);
        chk("midrst_data", 32'(o_data), 32'd0);
        i_rst = 1'b0;
        send(3); send(2); send(1);
        chk("midrst_incomplete", 32'(o_dval), 32'd0);
        send(0);
        chk_result("midrst", 3, 0, 0);
        idle(1);
        chk("midrst_pulses", 32'(pulses - base), 32'd1);

        // Reset arriving with the final beat suppresses the pulse
        base = pulses;
        send(5); send(6); send(7);
        i_dval = 1'b1;
        i_data = 12'd1;
        i_rst  = 1'b1;
        @(posedge i_clk);
        #1;
        i_dval = 1'b0;
        chk("rstlast_dval", 32'(o_dval), 32'd0);
        i_rst = 1'b0;
        idle(2);
        chk("rstlast_pulses", 32'(pulses - base), 32'd0);
        send(2); send(9); send(9); send(9);
        chk_result("rstlast_next", 0, 2, 1);
        idle(1);

        // Back-to-back pixels
        send(9); send(5); send(7); send(8);
        chk_result("b2b_first", 1, 5, 1);
        send(0);
        chk("b2b_between", 32'(o_dval), 32'd0);
        send(3); send(3); send(3);
        chk_result("b2b_second", 0, 0, 1);
        idle(1);

        // Maximum cost values
        send(4095); send(4095); send(4095); send(4095);
        chk_result("sat", 0, 4095, 0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
